// File: rtl/alu_src_pkg.sv
// Operand-mode encodings and the per-mode register-use table for the ID/EX operand stage.
package alu_src_pkg;

    localparam logic [2:0] SRC_R    = 3'd0;
    localparam logic [2:0] SRC_ZIMM = 3'd1;
    localparam logic [2:0] SRC_SIMM = 3'd2;
    localparam logic [2:0] SRC_SHV  = 3'd3;
    localparam logic [2:0] SRC_SHI  = 3'd4;
    localparam logic [2:0] SRC_LUI  = 3'd5;

    // Bit m set when mode m reads the operand; illegal modes 6/7 read nothing.
    localparam logic [7:0] RS_USE_MAP = 8'b0000_1111;
    localparam logic [7:0] RT_USE_MAP = 8'b0001_1001;

    function automatic logic uses_rs(input logic [2:0] mode);
        return RS_USE_MAP[mode];
    endfunction

    function automatic logic uses_rt(input logic [2:0] mode);
        return RT_USE_MAP[mode];
    endfunction

endpackage

// File: rtl/alu_fwd_select.sv
// Priority forwarding match for one source operand: lowest-index valid matching source wins.
module alu_fwd_select #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic [RA_W-1:0]         addr,
    input  logic [XLEN-1:0]         reg_val,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    hit,
    output logic                    pending
);

    always_comb begin
        value   = reg_val;
        hit     = 1'b0;
        pending = 1'b0;
        // Register 0 is hard-wired, so it never takes a forwarded value.
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && (addr != '0) && fwd_valid[i] &&
                (fwd_addr[i*RA_W +: RA_W] == addr)) begin
                hit     = 1'b1;
                value   = fwd_data[i*XLEN +: XLEN];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, ALU operand selection and a valid/ready output slot
// with load-use hazard stalling and a saturating stall counter.
module alu_operand_stage
    import alu_src_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned SH_W    = $clog2(XLEN),
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              src_ctrl,
    input  logic [RA_W-1:0]         rs_addr,
    input  logic [RA_W-1:0]         rt_addr,
    input  logic [XLEN-1:0]         reg_A,
    input  logic [XLEN-1:0]         reg_B,
    input  logic [SH_W-1:0]         shamt,
    input  logic [IMM_W-1:0]        imm,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_A,
    output logic [XLEN-1:0]         out_B,
    output logic                    bad_ctrl,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic [XLEN-1:0] rs_val, rt_val, nxt_A, nxt_B, imm_zext, imm_sext;
    logic            rs_hit, rt_hit, rs_pend, rt_pend;
    logic            nxt_bad, hazard, load;

    alu_fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rs (
        .addr(rs_addr), .reg_val(reg_A), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .value(rs_val), .hit(rs_hit), .pending(rs_pend)
    );

    alu_fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rt (
        .addr(rt_addr), .reg_val(reg_B), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .value(rt_val), .hit(rt_hit), .pending(rt_pend)
    );

    assign imm_zext = XLEN'(imm);
    assign imm_sext = XLEN'($signed(imm));

    always_comb begin
        nxt_A   = '0;
        nxt_B   = '0;
        nxt_bad = 1'b0;
        case (src_ctrl)
            SRC_R:    begin nxt_A = rs_val; nxt_B = rt_val;   end
            SRC_ZIMM: begin nxt_A = rs_val; nxt_B = imm_zext; end
            SRC_SIMM: begin nxt_A = rs_val; nxt_B = imm_sext; end
            SRC_SHV:  begin nxt_A = rt_val; nxt_B = XLEN'(rs_val[SH_W-1:0]); end
            SRC_SHI:  begin nxt_A = rt_val; nxt_B = XLEN'(shamt); end
            SRC_LUI:  begin nxt_A = '0;     nxt_B = imm_zext << (XLEN - IMM_W); end
            default:  begin nxt_A = '1;     nxt_B = '1; nxt_bad = 1'b1; end
        endcase
    end

    // A pending source only stalls when it is the winning match for an operand the mode reads.
    assign hazard   = in_valid & ((uses_rs(src_ctrl) & rs_hit & rs_pend) |
                                  (uses_rt(src_ctrl) & rt_hit & rt_pend));
    assign in_ready = ~hazard & (~out_valid | out_ready);
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_A     <= '0;
            out_B     <= '0;
            bad_ctrl  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_A     <= nxt_A;
                out_B     <= nxt_B;
                bad_ctrl  <= nxt_bad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus a randomized traffic phase.
module tb_alu_operand_stage;

    localparam int XLEN = 32, IMM_W = 16, RA_W = 5, SH_W = 5, NUM_FWD = 2, CNT_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n, flush, in_valid, in_ready, out_valid, out_ready, bad_ctrl;
    logic [2:0]              src_ctrl;
    logic [RA_W-1:0]         rs_addr, rt_addr;
    logic [XLEN-1:0]         reg_A, reg_B, out_A, out_B;
    logic [SH_W-1:0]         shamt;
    logic [IMM_W-1:0]        imm;
    logic [NUM_FWD-1:0]      fwd_valid, fwd_pending;
    logic [NUM_FWD*RA_W-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [CNT_W-1:0]        stall_cnt;

    typedef struct packed {
        logic        bad;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_stall = '0;

    alu_operand_stage #(
        .XLEN(XLEN), .IMM_W(IMM_W), .RA_W(RA_W), .SH_W(SH_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src_ctrl(src_ctrl), .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_A(reg_A), .reg_B(reg_B),
        .shamt(shamt), .imm(imm), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .bad_ctrl(bad_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {pending, value} for one operand.
    function automatic logic [32:0] fwd_pick(input logic [4:0] a, input logic [31:0] rv);
        if (a != 5'd0 && fwd_valid[0] && fwd_addr[4:0] == a) return {fwd_pending[0], fwd_data[31:0]};
        if (a != 5'd0 && fwd_valid[1] && fwd_addr[9:5] == a) return {fwd_pending[1], fwd_data[63:32]};
        return {1'b0, rv};
    endfunction

    function automatic exp_t model(input logic [2:0] m, input logic [31:0] rsv, input logic [31:0] rtv,
                                   input logic [4:0] sh, input logic [15:0] im);
        exp_t e;
        e.bad = 1'b0;
        case (m)
            3'd0: begin e.a = rsv; e.b = rtv; end
            3'd1: begin e.a = rsv; e.b = {16'h0000, im}; end
            3'd2: begin e.a = rsv; e.b = {{16{im[15]}}, im}; end
            3'd3: begin e.a = rtv; e.b = {27'd0, rsv[4:0]}; end
            3'd4: begin e.a = rtv; e.b = {27'd0, sh}; end
            3'd5: begin e.a = 32'd0; e.b = {im, 16'h0000}; end
            default: begin e.a = 32'hFFFF_FFFF; e.b = 32'hFFFF_FFFF; e.bad = 1'b1; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        logic [32:0] ps, pt;
        logic        haz, mv, exp_rdy;
        exp_t        e;
        if (!rst_n) begin
            sb.delete();
            exp_stall = '0;
        end else begin
            ps      = fwd_pick(rs_addr, reg_A);
            pt      = fwd_pick(rt_addr, reg_B);
            haz     = in_valid && (((src_ctrl <= 3'd3) && ps[32]) ||
                                   ((src_ctrl == 3'd0 || src_ctrl == 3'd3 || src_ctrl == 3'd4) && pt[32]));
            mv      = (sb.size() != 0);
            exp_rdy = !haz && (!mv || out_ready);
            check_eq("out_valid", 64'(out_valid), 64'(mv));
            check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
            check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (mv && (flush || out_ready)) begin
                e = sb.pop_front();
                if (!flush) begin
                    check_eq("slot_A", 64'(out_A), 64'(e.a));
                    check_eq("slot_B", 64'(out_B), 64'(e.b));
                    check_eq("slot_bad", 64'(bad_ctrl), 64'(e.bad));
                end
            end
            if (in_valid && exp_rdy && !flush)
                sb.push_back(model(src_ctrl, ps[31:0], pt[31:0], shamt, imm));
            if (haz && !flush && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; src_ctrl = 0; rs_addr = 0; rt_addr = 0;
        reg_A = 0; reg_B = 0; shamt = 0; imm = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    initial begin
        idle();
        rst_n = 0; out_ready = 1;
        step(); step();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_A", 64'(out_A), 64'd0);
        check_eq("rst_B", 64'(out_B), 64'd0);
        check_eq("rst_bad", 64'(bad_ctrl), 64'd0);
        check_eq("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1;
        step();

        // Sign-extended immediate
        src_ctrl = 3'd2; imm = 16'h8001; reg_A = 32'd5; rs_addr = 5'd1; rt_addr = 5'd2; in_valid = 1;
        step(); idle();
        check_eq("simm_valid", 64'(out_valid), 64'd1);
        check_eq("simm_A", 64'(out_A), 64'd5);
        check_eq("simm_B", 64'(out_B), 64'hFFFF_8001);

        // Forward priority: source 0 beats source 1
        src_ctrl = 3'd0; rs_addr = 5'd3; reg_A = 32'h11; fwd_valid = 2'b11;
        fwd_addr = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA}; in_valid = 1;
        step();
        check_eq("fwd_prio_A", 64'(out_A), 64'hAA);
        // Address 0 never matches
        rs_addr = 5'd0; fwd_addr = 10'd0;
        step(); idle();
        check_eq("fwd_zero_A", 64'(out_A), 64'h11);

        // Pending low-priority match shadowed by a ready one: no hazard
        src_ctrl = 3'd0; rs_addr = 5'd5; fwd_valid = 2'b11; fwd_pending = 2'b10;
        fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h2, 32'h1}; in_valid = 1;
        #1 check_eq("shadow_rdy", 64'(in_ready), 64'd1);
        step(); idle();
        check_eq("shadow_A", 64'(out_A), 64'h1);

        // Load-use hazard for 3 cycles
        src_ctrl = 3'd1; rs_addr = 5'd4; imm = 16'h0042; fwd_valid = 2'b01; fwd_pending = 2'b01;
        fwd_addr = {5'd0, 5'd4}; fwd_data = {32'h0, 32'hCAFE}; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("haz_rdy", 64'(in_ready), 64'd0);
            step();
        end
        check_eq("haz_cnt3", 64'(stall_cnt), 64'd3);
        fwd_pending = 2'b00;
        #1 check_eq("haz_clear_rdy", 64'(in_ready), 64'd1);
        step();
        in_valid = 0;
        check_eq("haz_A", 64'(out_A), 64'hCAFE);
        check_eq("haz_B", 64'(out_B), 64'h42);
        // Mode 4 does not read rs, so the same pending source is ignored
        src_ctrl = 3'd4; rt_addr = 5'd7; reg_B = 32'h99; shamt = 5'd9; fwd_pending = 2'b01; in_valid = 1;
        #1 check_eq("shi_rdy", 64'(in_ready), 64'd1);
        step(); in_valid = 0;
        check_eq("shi_A", 64'(out_A), 64'h99);
        check_eq("shi_B", 64'(out_B), 64'd9);
        check_eq("shi_cnt", 64'(stall_cnt), 64'd3);

        // Counter saturation
        src_ctrl = 3'd1; in_valid = 1;
        repeat (14) step();
        check_eq("cnt_sat", 64'(stall_cnt), 64'hF);
        idle();

        // Variable shift, then LUI and illegal mode back to back
        src_ctrl = 3'd3; rs_addr = 5'd1; reg_A = 32'h12345; rt_addr = 5'd6; reg_B = 32'h77; in_valid = 1;
        step();
        check_eq("shv_A", 64'(out_A), 64'h77);
        check_eq("shv_B", 64'(out_B), 64'h05);
        src_ctrl = 3'd5; imm = 16'h1234;
        step();
        check_eq("lui_A", 64'(out_A), 64'd0);
        check_eq("lui_B", 64'(out_B), 64'h1234_0000);
        check_eq("lui_bad", 64'(bad_ctrl), 64'd0);
        src_ctrl = 3'd7;
        step(); idle();
        check_eq("ill_A", 64'(out_A), 64'hFFFF_FFFF);
        check_eq("ill_B", 64'(out_B), 64'hFFFF_FFFF);
        check_eq("ill_bad", 64'(bad_ctrl), 64'd1);
        step();

        // Backpressure holds the slot; flush beats a simultaneous load
        out_ready = 0; src_ctrl = 3'd0; rs_addr = 5'd1; rt_addr = 5'd2;
        reg_A = 32'hA5A5; reg_B = 32'h5A5A; in_valid = 1;
        step();
        reg_A = 32'h1; reg_B = 32'h2;
        #1 check_eq("bp_rdy", 64'(in_ready), 64'd0);
        step(); step();
        check_eq("bp_A", 64'(out_A), 64'hA5A5);
        check_eq("bp_B", 64'(out_B), 64'h5A5A);
        check_eq("bp_valid", 64'(out_valid), 64'd1);
        flush = 1; out_ready = 1;
        step(); idle();
        check_eq("flush_valid", 64'(out_valid), 64'd0);

        // Reset while the slot is full and an input is stalled
        out_ready = 0; src_ctrl = 3'd0; rs_addr = 5'd1; reg_A = 32'h33; in_valid = 1;
        step();
        src_ctrl = 3'd1; rs_addr = 5'd4; fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd4};
        step();
        rst_n = 0;
        step();
        check_eq("rst2_valid", 64'(out_valid), 64'd0);
        check_eq("rst2_A", 64'(out_A), 64'd0);
        check_eq("rst2_B", 64'(out_B), 64'd0);
        check_eq("rst2_bad", 64'(bad_ctrl), 64'd0);
        check_eq("rst2_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1; idle(); out_ready = 1;
        step(); step();
        check_eq("no_reemit", 64'(out_valid), 64'd0);

        // Randomized traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            src_ctrl    = 3'($urandom_range(0, 7));
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 7));
            reg_A       = $urandom;
            reg_B       = $urandom;
            shamt       = 5'($urandom);
            imm         = 16'($urandom);
            fwd_valid   = 2'($urandom);
            fwd_pending = 2'(($urandom_range(0, 3) == 0) ? $urandom : 0);
            fwd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data    = {$urandom, $urandom};
            step();
        end
        idle(); out_ready = 1;
        step(); step(); step();
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
